hbm_port_scheduler: RTL and testbench

HBM_PORT_SCHEDULER -- requirements
Module: hbm_port_scheduler

---
 rtl/hbm_port_scheduler.sv | 178 +++++++++++++++++
 tb/tb_hbm_port_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hbm_port_scheduler.sv
`default_nettype none
// =============================================================================
// hbm_port_scheduler : round-robin edge-read issue across HBM controller ports
//                      with per-port credit tracking and a drain handshake.
// Revision 1.0
// =============================================================================
`ifndef HBM_AWIDTH
`define HBM_AWIDTH 28
`endif

module hbm_port_scheduler #(
   parameter int HBM_AWIDTH      = `HBM_AWIDTH,
   parameter int PORT_NUM        = 4,
   parameter int MAX_OUTSTANDING = 16,
   parameter int CNT_WIDTH       = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [HBM_AWIDTH-1:0]          rqst_addr,
   input  logic                           rqst_valid,
   output logic                           rqst_ready,
   input  logic [PORT_NUM-1:0]            hbm_controller_full,
   input  logic [PORT_NUM-1:0]            hbm_controller_valid,
   output logic [PORT_NUM*HBM_AWIDTH-1:0] rd_hbm_edge_addr,
   output logic [PORT_NUM-1:0]            rd_hbm_edge_valid,
   input  logic                           drain_start,
   output logic                           drain_done,
   output logic                           busy,
   output logic                           err_underflow
);

   localparam int                   PTR_W     = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
   localparam int                   SUM_W     = PTR_W + 1;
   localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);
   localparam logic [PTR_W-1:0]     LAST_PORT = PTR_W'(PORT_NUM - 1);
   localparam logic [PTR_W-1:0]     ONE_PTR   = PTR_W'(1);
   localparam logic [SUM_W-1:0]     PORTS_SUM = SUM_W'(PORT_NUM);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    grant;
   logic                any_elig;
   logic                accept;
   logic [PORT_NUM-1:0] valid_q, valid_d;
   logic [PORT_NUM-1:0] elig;
   logic [PORT_NUM-1:0] uflow;
   logic [PORT_NUM-1:0] nonzero;
   logic                err_q, err_d;

   // Circular scan starting at ptr; first eligible port wins.
   always_comb begin
      logic [SUM_W-1:0] sum;
      logic [PTR_W-1:0] idx;
      grant    = ptr_q;
      any_elig = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
         sum = {1'b0, ptr_q} + SUM_W'(i);
         if (sum >= PORTS_SUM) begin
            sum = sum - PORTS_SUM;
         end
         idx = sum[PTR_W-1:0];
         if (!any_elig && elig[idx]) begin
            any_elig = 1'b1;
            grant    = idx;
         end
      end
   end

   assign accept = rqst_valid && rqst_ready;

   always_comb begin
      valid_d = '0;
      if (accept) begin
         valid_d[grant] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (grant == LAST_PORT) ? '0 : grant + ONE_PTR;
      end
   end

   assign err_d = err_q | (|uflow);

   // Next-state and state-decoded outputs.
   always_comb begin
      state_d    = state_q;
      rqst_ready = 1'b0;
      drain_done = 1'b0;
      case (state_q)
         ST_RUN: begin
            rqst_ready = any_elig;
            if (drain_start) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((nonzero == '0) && (valid_q == '0)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            drain_done = 1'b1;
            state_d    = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         ptr_q   <= '0;
         valid_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
      logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
      logic [HBM_AWIDTH-1:0] addr_q;
      logic                  inc;
      logic                  dec;

      assign inc        = accept && (grant == PTR_W'(p));
      assign dec        = hbm_controller_valid[p];
      assign uflow[p]   = dec && !inc && (cnt_q == '0);
      assign nonzero[p] = (cnt_q != '0);
      assign elig[p]    = !hbm_controller_full[p] && (cnt_q < MAX_CNT);

      // Issue and return in the same cycle cancel; a return at zero is dropped.
      always_comb begin
         cnt_d = cnt_q;
         if (inc && !dec) begin
            cnt_d = cnt_q + ONE_CNT;
         end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE_CNT;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
         end else begin
            cnt_q <= cnt_d;
            if (inc) begin
               addr_q <= rqst_addr;
            end
         end
      end

      assign rd_hbm_edge_addr[p*HBM_AWIDTH +: HBM_AWIDTH] = addr_q;
   end

   assign rd_hbm_edge_valid = valid_q;
   assign err_underflow     = err_q;
   assign busy              = (state_q != ST_RUN) || (nonzero != '0) || (valid_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_hbm_port_scheduler.sv
`default_nettype none
// =============================================================================
// tb_hbm_port_scheduler : directed vector table plus drain/credit/reset sequences.
// Revision 1.0
// =============================================================================
module tb_hbm_port_scheduler;

   localparam int AW = 16;
   localparam int PN = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [AW-1:0]   rqst_addr = '0;
   logic            rqst_valid = 1'b0;
   logic            rqst_ready;
   logic [PN-1:0]   full = '0;
   logic [PN-1:0]   hv = '0;
   logic [PN*AW-1:0] edge_addr;
   logic [PN-1:0]   edge_valid;
   logic            drain_start = 1'b0;
   logic            drain_done;
   logic            busy;
   logic            err;

   int   checks = 0;
   int   errors = 0;
   logic rdy_s;

   hbm_port_scheduler #(
      .HBM_AWIDTH      (AW),
      .PORT_NUM        (PN),
      .MAX_OUTSTANDING (16),
      .CNT_WIDTH       (5)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .rqst_addr            (rqst_addr),
      .rqst_valid           (rqst_valid),
      .rqst_ready           (rqst_ready),
      .hbm_controller_full  (full),
      .hbm_controller_valid (hv),
      .rd_hbm_edge_addr     (edge_addr),
      .rd_hbm_edge_valid    (edge_valid),
      .drain_start          (drain_start),
      .drain_done           (drain_done),
      .busy                 (busy),
      .err_underflow        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [15:0]   a;
      logic [3:0]    f;
      logic [3:0]    r;
      logic          d;
      logic          e_rdy;
      logic [3:0]    e_val;
      logic [63:0]   e_addr;
      logic          e_busy;
      logic          e_done;
      logic          e_err;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive at negedge, sample ready before the edge, then settle after posedge.
   task automatic step(input logic v, input logic [15:0] a, input logic [3:0] f,
                       input logic [3:0] r, input logic d);
      @(negedge clk);
      rqst_valid  = v;
      rqst_addr   = a;
      full        = f;
      hv          = r;
      drain_start = d;
      #1 rdy_s = rqst_ready;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ev;

      //            v     addr     full     ret      drn   rdy   val      addr                    busy  done  err
      tbl[0]  = '{1'b1, 16'h0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 64'h0000_0000_0000_0010, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 16'h0011, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010, 64'h0000_0000_0011_0010, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 16'h0012, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 64'h0000_0012_0011_0010, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 16'h0013, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1000, 64'h0013_0012_0011_0010, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 4'b0000, 64'h0013_0012_0011_0010, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 16'h0030, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 64'h0013_0012_0011_0030, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 16'h0020, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0100, 64'h0013_0020_0011_0030, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 16'h0021, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1000, 64'h0021_0020_0011_0030, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 16'h0000, 4'b0000, 4'b1101, 1'b0, 1'b1, 4'b0000, 64'h0021_0020_0011_0030, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 16'h0055, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 64'h0021_0020_0011_0030, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 16'h0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 4'b0000, 64'h0021_0020_0011_0030, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 64'h0021_0020_0011_0030, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 16'h0040, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b0001, 64'h0021_0020_0011_0040, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 64'h0021_0020_0011_0040, 1'b0, 1'b0, 1'b1};

      // Reset state
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.valid", edge_valid, 4'b0000);
      chk("reset.addr", edge_addr, 64'h0);
      chk("reset.busy", busy, 1'b0);
      chk("reset.done", drain_done, 1'b0);
      chk("reset.err", err, 1'b0);
      chk("reset.ready", rqst_ready, 1'b1);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].a, tbl[i].f, tbl[i].r, tbl[i].d);
         chk($sformatf("vec%0d.ready", i), rdy_s, tbl[i].e_rdy);
         chk($sformatf("vec%0d.valid", i), edge_valid, tbl[i].e_val);
         chk($sformatf("vec%0d.addr", i), edge_addr, tbl[i].e_addr);
         chk($sformatf("vec%0d.busy", i), busy, tbl[i].e_busy);
         chk($sformatf("vec%0d.done", i), drain_done, tbl[i].e_done);
         chk($sformatf("vec%0d.err", i), err, tbl[i].e_err);
      end

      // Credit limit on the only non-full port
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 16'h0100 + 16'(i), 4'b1110, 4'b0000, 1'b0);
         chk($sformatf("max.req%0d.ready", i), rdy_s, 1'b1);
         chk($sformatf("max.req%0d.valid", i), edge_valid, 4'b0001);
      end
      chk("max.last_addr", edge_addr[15:0], 16'h010F);
      step(1'b1, 16'h01FF, 4'b1110, 4'b0000, 1'b0);
      chk("max.req16.ready", rdy_s, 1'b0);
      chk("max.req16.valid", edge_valid, 4'b0000);
      step(1'b0, 16'h0000, 4'b1110, 4'b0001, 1'b0);
      chk("max.return_cycle.ready", rdy_s, 1'b0);
      step(1'b1, 16'h01AA, 4'b1110, 4'b0000, 1'b0);
      chk("max.after_return.ready", rdy_s, 1'b1);
      chk("max.after_return.valid", edge_valid, 4'b0001);
      chk("max.after_return.addr", edge_addr[15:0], 16'h01AA);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 16'h0000, 4'b0000, 4'b0001, 1'b0);
      end
      chk("max.drained.busy", busy, 1'b0);

      // Drain with 8 outstanding; the 8th accept coincides with drain_start
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 16'h0200 + 16'(i), 4'b0000, 4'b0000, (i == 7) ? 1'b1 : 1'b0);
         ev = 4'b0001 << ((1 + i) % 4);
         chk($sformatf("drain.req%0d.ready", i), rdy_s, 1'b1);
         chk($sformatf("drain.req%0d.valid", i), edge_valid, ev);
      end
      for (int k = 0; k < 8; k++) begin
         ev = 4'b0001 << (k % 4);
         step(1'b1, 16'h0300, 4'b0000, ev, (k == 2) ? 1'b1 : 1'b0);
         chk($sformatf("drain.ret%0d.ready", k), rdy_s, 1'b0);
         chk($sformatf("drain.ret%0d.valid", k), edge_valid, 4'b0000);
         chk($sformatf("drain.ret%0d.done", k), drain_done, 1'b0);
         chk($sformatf("drain.ret%0d.busy", k), busy, 1'b1);
      end
      step(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0);
      chk("drain.pulse.ready", rdy_s, 1'b0);
      chk("drain.pulse.done", drain_done, 1'b1);
      chk("drain.pulse.busy", busy, 1'b1);
      step(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0);
      chk("drain.after.ready", rdy_s, 1'b0);
      chk("drain.after.done", drain_done, 1'b0);
      chk("drain.after.busy", busy, 1'b0);
      step(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0);
      chk("drain.run.ready", rdy_s, 1'b1);

      // Asynchronous reset mid-drain with 5 outstanding and a strobe in flight
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 16'h0400 + 16'(i), 4'b0000, 4'b0000, (i == 4) ? 1'b1 : 1'b0);
      end
      chk("rstmid.pre.valid", edge_valid, 4'b0010);
      chk("rstmid.pre.addr1", edge_addr[31:16], 16'h0404);
      chk("rstmid.pre.err", err, 1'b1);
      rqst_valid  = 1'b0;
      drain_start = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rstmid.valid", edge_valid, 4'b0000);
      chk("rstmid.addr", edge_addr, 64'h0);
      chk("rstmid.done", drain_done, 1'b0);
      chk("rstmid.err", err, 1'b0);
      chk("rstmid.busy", busy, 1'b0);
      chk("rstmid.ready", rqst_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 16'h0000, 4'b0000, 4'b0010, 1'b0);
      chk("rstmid.release.ready", rdy_s, 1'b1);
      chk("rstmid.stale_return.err", err, 1'b1);
      chk("rstmid.stale_return.busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
